sha256_compress_core: RTL and testbench
=======================================

Name: sha256_compress_core

Overview:
- Single-block SHA-256 compression engine, one round per clock.
- Holds the 16-word message-schedule window and the working variables a..h.
- Drives the round index to the K-constant lookup and consumes the returned K combinationally in the same cycle.
- Adds the result to the incoming chaining value; the message padder/block feeder sits upstream.

Parameters:
- None. Widths are fixed by SHA-256.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to compress one block; honoured only in IDLE.
- block_in  input  512  message block; [511:480]=W0 … [31:0]=W15, big-endian words.
- hash_in  input  256  chaining value; [255:224]=H0 … [31:0]=H7.
- round  output  6  current round index to K lookup; 0 when not in ROUND.
- K  input  32  round constant for `round`, combinational from the lookup.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; hash_out valid from this cycle.
- hash_out  output  256  H_in + final a..h, same packing as hash_in; held until the next done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, round=0, hash_out=0. All state returns to IDLE. Window, working and H registers are cleared to 0.
- States: IDLE, ROUND, FINAL.
- IDLE, start=1 at an edge:
  - Capture hash_in into H0..H7 and into a..h.
  - Capture block_in into w[0..15].
  - Set round=0, busy=1, go to ROUND.
- IDLE, start=0: stay in IDLE; done=0.
- ROUND, at each edge:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K + w[0].
  - T2 = Σ0(a) + Maj(a,b,c).
  - Update working variables: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Shift the window: w[i]←w[i+1] for i=0..14; w[15]←σ1(w[14])+w[9]+σ0(w[1])+w[0].
  - All additions are mod 2^32, with carries discarded.
  - If round==63, go to FINAL with round←0; otherwise round←round+1.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22.
  - Σ1 = ROTR6^ROTR11^ROTR25.
  - σ0 = ROTR7^ROTR18^SHR3.
  - σ1 = ROTR17^ROTR19^SHR10.
- FINAL, at the edge:
  - hash_out[j] ← H[j] + var[j], per 32-bit word, mod 2^32.
  - done←1, busy←0, go to IDLE.
- Latency:
  - Start accepted at edge 0.
  - Rounds 0..63 execute at edges 1..64.
  - FINAL executes at edge 65; done is high for the cycle following edge 65.
  - Throughput is one block per 66 cycles.
- done is cleared at the next edge unconditionally.
- start with done=1 in the same cycle: accepted, since state is IDLE. This allows back-to-back blocks with a 66-cycle period.
- start while busy: ignored; no effect on state or outputs.
- block_in and hash_in are sampled only at the accept edge. Later changes have no effect.
- Reset mid-operation: immediate abort to reset values. No done is generated for the aborted block.
- round is registered, so the K lookup settles within the same cycle it is used.

Optional Feature:
- Macro: SHA256_INIT_IV_EN.
- Defined:
  - Adds input port init (1 bit).
  - When init=1 at an accepted start, H0..H7 and a..h load the FIPS-180-4 IV instead of hash_in: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - init=0 uses hash_in.
- Undefined: the port is absent and hash_in is always used.

Test Plan:
- Empty message: block=80000000 followed by zeros, hash_in=IV, start -> done exactly 66 cycles later. hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc": block=61626380, zeros, W15=00000018, hash_in=IV -> hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Two-block 448-bit message "abcdbcdecdefdefgefghfghighijhijkijkljklmjklmnklmnlmnomnopnopq":
  - Start the second block in the done cycle of the first, with hash_in=first hash_out.
  - Final hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
  - Block period = 66 cycles.
- Round sequencing: monitor round during a block -> 0,1,…,63 on consecutive cycles while busy, then 0. Check K=428a2f98 at round 0 and K=c67178f2 at round 63.
- start pulsed at round 10 with a different block -> ignored; the "abc" result is unchanged and only one done occurs.
- rst_n asserted at round 30 -> busy, done, round, hash_out go to 0 asynchronously. Release and restart "abc" -> correct digest, no spurious done.

Source files
------------

// File: rtl/sha256_compress_core.sv
// sha256_compress_core: SHA-256 compression of one 512-bit block, one round per clock.
// Optional feature macro SHA256_INIT_IV_EN adds an `init` input that selects the FIPS-180-4 IV.
//
// Handshake: start is sampled only while IDLE (including the cycle done is high). busy is
// high from the cycle after acceptance until done; done is a one-cycle pulse and hash_out
// is valid from that cycle and held until the next done. block_in/hash_in are sampled once
// at the accept edge.
module sha256_compress_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
`ifdef SHA256_INIT_IV_EN
    input  logic         init,
`endif
    output logic [5:0]   round,
    input  logic [31:0]  K,
    output logic         busy,
    output logic         done,
    output logic [255:0] hash_out,
    output logic [1:0]   dbg_state
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ROUND = 2'd1;
    localparam logic [1:0] FINAL = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [5:0]        round_q, round_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [255:0]      hash_q, hash_d;
    logic [7:0][31:0]  h_q, h_d;   // chaining value H0..H7
    logic [7:0][31:0]  v_q, v_d;   // working variables, index 0 = a ... 7 = h
    logic [15:0][31:0] w_q, w_d;   // schedule window, w[0] is the word used this round

    logic [255:0] chain_in;
    logic [31:0]  t1, t2, w_new;

`ifdef SHA256_INIT_IV_EN
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    assign chain_in = init ? IV : hash_in;
`else
    assign chain_in = hash_in;
`endif

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // K arrives combinationally from the external lookup addressed by round_q.
    assign t1 = v_q[7] + big_sigma1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K + w_q[0];
    assign t2 = big_sigma0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    assign w_new = small_sigma1(w_q[14]) + w_q[9] + small_sigma0(w_q[1]) + w_q[0];

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hash_d  = hash_q;
        h_d     = h_q;
        v_d     = v_q;
        w_d     = w_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int j = 0; j < 8; j++) begin
                        h_d[j] = chain_in[255-32*j -: 32];
                        v_d[j] = chain_in[255-32*j -: 32];
                    end
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = block_in[511-32*i -: 32];
                    end
                    round_d = 6'd0;
                    busy_d  = 1'b1;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                v_d[7] = v_q[6];
                v_d[6] = v_q[5];
                v_d[5] = v_q[4];
                v_d[4] = v_q[3] + t1;
                v_d[3] = v_q[2];
                v_d[2] = v_q[1];
                v_d[1] = v_q[0];
                v_d[0] = t1 + t2;
                for (int i = 0; i < 15; i++) begin
                    w_d[i] = w_q[i+1];
                end
                w_d[15] = w_new;
                if (round_q == 6'd63) begin
                    round_d = 6'd0;
                    state_d = FINAL;
                end else begin
                    round_d = round_q + 6'd1;
                end
            end
            FINAL: begin
                for (int j = 0; j < 8; j++) begin
                    hash_d[255-32*j -: 32] = h_q[j] + v_q[j];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                round_d = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            round_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hash_q  <= '0;
            h_q     <= '0;
            v_q     <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hash_q  <= hash_d;
            h_q     <= h_d;
            v_q     <= v_d;
            w_q     <= w_d;
        end
    end

    assign round     = round_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign hash_out  = hash_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Self-checking bench for sha256_compress_core: FIPS vectors, timing, ignored start,
// mid-block reset and randomized blocks against a plain 64-word SHA-256 model.
module tb_sha256_compress_core;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [511:0] block_in = '0;
    logic [255:0] hash_in = '0;
    logic [5:0]   round;
    logic [31:0]  K;
    logic         busy;
    logic         done;
    logic [255:0] hash_out;
    logic [1:0]   dbg_state;
`ifdef SHA256_INIT_IV_EN
    logic         init = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] IV      = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [255:0] D_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [255:0] D_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_TWO   = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    assign K = k_tab[round];

    sha256_compress_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .block_in  (block_in),
        .hash_in   (hash_in),
`ifdef SHA256_INIT_IV_EN
        .init      (init),
`endif
        .round     (round),
        .K         (K),
        .busy      (busy),
        .done      (done),
        .hash_out  (hash_out),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_model(input logic [511:0] blk, input logic [255:0] hin);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int j = 0; j < 8; j++) v[j] = hin[255-32*j -: 32];
        for (int r = 0; r < 64; r++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tab[r] + w[r];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255-32*j -: 32] = hin[255-32*j -: 32] + v[j];
        return res;
    endfunction

    function automatic logic [255:0] chain_sel();
`ifdef SHA256_INIT_IV_EN
        return init ? IV : hash_in;
`else
        return hash_in;
`endif
    endfunction

    // ---------------- scoreboard ----------------
    // p = cycles since the accept edge (1 = first round cycle, 66 = done cycle), 0 = idle.
    logic [255:0] exp_q[$];
    logic [255:0] last_exp = '0;
    int           p = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p = 0;
            exp_q.delete();
            last_exp = '0;
        end else if ((p == 0 || p == 66) && start) begin
            exp_q.push_back(sha_model(block_in, chain_sel()));
            p = 1;
        end else if (p == 66) begin
            p = 0;
        end else if (p > 0) begin
            p++;
            if (p == 66 && exp_q.size() > 0) last_exp = exp_q.pop_front();
        end
    end

    always @(negedge clk) begin
        chk("busy", {255'd0, busy}, {255'd0, (p >= 1 && p <= 65)});
        chk("done", {255'd0, done}, {255'd0, (p == 66)});
        chk("round", {250'd0, round}, (p >= 1 && p <= 64) ? 256'(p - 1) : 256'd0);
        chk("hash_out", hash_out, last_exp);
    end

    // ---------------- drivers ----------------
    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    function automatic logic [255:0] rand_hash();
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom();
        return h;
    endfunction

    // Called at a negedge while the core is idle; returns at the negedge of round 0.
    task automatic start_block(input logic [511:0] blk, input logic [255:0] hin);
        block_in = blk;
        hash_in  = hin;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
`ifdef SHA256_INIT_IV_EN
        init     = 1'b0;
`endif
        block_in = rand_block();
        hash_in  = rand_hash();
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        if (done !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles, required done", cyc);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [255:0] h1_exp;
    int           cyc;
    int           n_done;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_busy", {255'd0, busy}, 256'd0);
        chk("reset_done", {255'd0, done}, 256'd0);
        chk("reset_round", {250'd0, round}, 256'd0);
        chk("reset_hash", hash_out, 256'd0);
        rst_n = 1'b1;

        // pin the model itself to the published digests
        h1_exp = sha_model(B_TWO1, IV);
        chk("model_empty", sha_model(B_EMPTY, IV), D_EMPTY);
        chk("model_abc", sha_model(B_ABC, IV), D_ABC);
        chk("model_two", sha_model(B_TWO2, h1_exp), D_TWO);
        @(negedge clk);

        // empty message with exact latency
        start_block(B_EMPTY, IV);
        wait_done(cyc);
        chk("latency_empty", 256'(cyc + 1), 256'd66);
        chk("digest_empty", hash_out, D_EMPTY);
        repeat (3) @(negedge clk);

        // "abc" with round/K sequencing endpoints
        start_block(B_ABC, IV);
        chk("k_round0", {224'd0, K}, {224'd0, 32'h428a2f98});
        repeat (63) @(negedge clk);
        chk("round63", {250'd0, round}, 256'd63);
        chk("k_round63", {224'd0, K}, {224'd0, 32'hc67178f2});
        wait_done(cyc);
        chk("digest_abc", hash_out, D_ABC);
        repeat (2) @(negedge clk);

        // two-block message, second start in the done cycle of the first
        start_block(B_TWO1, IV);
        wait_done(cyc);
        start_block(B_TWO2, h1_exp);
        wait_done(cyc);
        chk("period_two", 256'(cyc + 1), 256'd66);
        chk("digest_two", hash_out, D_TWO);
        repeat (2) @(negedge clk);

        // start while busy is ignored
        start_block(B_ABC, IV);
        repeat (10) @(negedge clk);
        block_in = rand_block();
        hash_in  = rand_hash();
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(cyc);
        chk("digest_abc_ignored_start", hash_out, D_ABC);
        n_done = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("extra_done_count", 256'(n_done), 256'd0);

        // reset in the middle of a block
        start_block(B_ABC, IV);
        repeat (30) @(negedge clk);
        chk("round30", {250'd0, round}, 256'd30);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_done", {255'd0, done}, 256'd0);
        chk("abort_round", {250'd0, round}, 256'd0);
        chk("abort_hash", hash_out, 256'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start_block(B_ABC, IV);
        wait_done(cyc);
        chk("digest_abc_after_reset", hash_out, D_ABC);
        @(negedge clk);

`ifdef SHA256_INIT_IV_EN
        init = 1'b1;
        start_block(B_ABC, rand_hash());
        wait_done(cyc);
        chk("digest_abc_init_iv", hash_out, D_ABC);
        @(negedge clk);
`endif

        // randomized blocks, random gaps including back-to-back
        for (int n = 0; n < 24; n++) begin
`ifdef SHA256_INIT_IV_EN
            init = 1'($urandom_range(0, 1));
`endif
            start_block(rand_block(), rand_hash());
            wait_done(cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
